// File: rtl/cryptarch_pkg.sv
// rtl/cryptarch_pkg.sv - shared cipher types, round-count constants and GF(2^8) helpers
package cryptarch_pkg;

    typedef logic [3:0][3:0][7:0] state_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} eng_state_e;

    localparam int NR_AES128 = 10;
    localparam int NR_AES192 = 12;
    localparam int NR_AES256 = 14;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // S-box built algebraically: x^254 is the field inverse (0 maps to 0), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/round_engine_datapath.sv
// rtl/round_engine_datapath.sv - one combinational cipher round and its helper stages
module substitutekey
    import cryptarch_pkg::*;
(
    input  state_t st_i,
    output state_t st_o
);
    // Byte substitution fused with the row rotation: row r shifts left by r columns.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign st_o[r][c] = sbox(st_i[r][(c + r) % 4]);
        end
    end
endmodule

module diffusion
    import cryptarch_pkg::*;
(
    input  state_t st_i,
    output state_t st_o
);
    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = st_i[0][c];
        assign a1 = st_i[1][c];
        assign a2 = st_i[2][c];
        assign a3 = st_i[3][c];
        assign st_o[0][c] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign st_o[1][c] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign st_o[2][c] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign st_o[3][c] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
endmodule

module addroundkey
    import cryptarch_pkg::*;
(
    input  state_t st_i,
    input  state_t rk_i,
    output state_t st_o
);
    assign st_o = st_i ^ rk_i;
endmodule

module round_datapath
    import cryptarch_pkg::*;
(
    input  state_t st_i,
    input  state_t rk_i,
    input  logic   last_i,
    output state_t next_st_o
);
    state_t sub_st;
    state_t mix_st;
    state_t pre_key_st;

    substitutekey u_sub (.st_i(st_i), .st_o(sub_st));
    diffusion     u_mix (.st_i(sub_st), .st_o(mix_st));

    assign pre_key_st = last_i ? sub_st : mix_st;

    addroundkey   u_ark (.st_i(pre_key_st), .rk_i(rk_i), .st_o(next_st_o));
endmodule

// File: rtl/round_engine.sv
// rtl/round_engine.sv - iterative block-cipher core with whitening, handshakes and key indexing
module round_engine
    import cryptarch_pkg::*;
#(
    parameter int NR       = NR_AES128,
    parameter int RK_IDX_W = $clog2(NR + 1)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  state_t              in_data_i,
    output logic [RK_IDX_W-1:0] rk_idx_o,
    input  state_t              rk_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output state_t              out_data_o,
    output logic                busy_o
);
    localparam logic [RK_IDX_W-1:0] LAST_IDX = RK_IDX_W'(NR);
    localparam logic [RK_IDX_W-1:0] FIRST_IDX = RK_IDX_W'(1);

    eng_state_e          state_q, state_d;
    logic [RK_IDX_W-1:0] ctr_q, ctr_d;
    state_t              st_q, st_d;
    state_t              dp_next;
    logic                last_round;

    assign last_round = (ctr_q == LAST_IDX);

    round_datapath u_dp (
        .st_i      (st_q),
        .rk_i      (rk_i),
        .last_i    (last_round),
        .next_st_o (dp_next)
    );

    always_comb begin
        state_d    = state_q;
        ctr_d      = ctr_q;
        st_d       = st_q;
        in_ready_o = 1'b0;
        rk_idx_o   = '0;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    st_d    = in_data_i ^ rk_i;
                    ctr_d   = FIRST_IDX;
                    state_d = RUN;
                end
            end
            RUN: begin
                rk_idx_o = ctr_q;
                st_d     = dp_next;
                if (last_round) begin
                    state_d = DONE;
                end else begin
                    ctr_d = ctr_q + FIRST_IDX;
                end
            end
            DONE: begin
                // Result leaves and a new block is whitened on the same edge.
                in_ready_o = out_ready_i;
                if (out_ready_i) begin
                    if (in_valid_i) begin
                        st_d    = in_data_i ^ rk_i;
                        ctr_d   = FIRST_IDX;
                        state_d = RUN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            st_q    <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            st_q    <= st_d;
        end
    end

    assign out_valid_o = (state_q == DONE);
    assign busy_o      = (state_q != IDLE);
    assign out_data_o  = out_valid_o ? st_q : '0;

endmodule

// File: tb/tb_round_engine.sv
// tb/tb_round_engine.sv - directed FIPS-197 vectors against NR=10 and NR=14 builds
module tb_round_engine;
    import cryptarch_pkg::*;

    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, out_valid, out_ready, busy;
    state_t     in_data, rk, out_data;
    logic [3:0] rk_idx;
    logic       in_valid14, in_ready14, out_valid14, out_ready14, busy14;
    state_t     in_data14, rk14, out_data14;
    logic [3:0] rk_idx14;

    state_t      rk10_tab [0:10];
    state_t      rk14_tab [0:14];
    logic [31:0] w        [0:59];
    logic [7:0]  gexp     [0:255];
    int          glog     [0:255];

    int checks = 0;
    int errors = 0;
    int n;
    state_t held;

    assign rk   = rk10_tab[rk_idx];
    assign rk14 = rk14_tab[rk_idx14];

    round_engine #(.NR(10)) dut10 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .rk_idx_o(rk_idx), .rk_i(rk), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .busy_o(busy)
    );

    round_engine #(.NR(14)) dut14 (
        .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid14), .in_ready_o(in_ready14),
        .in_data_i(in_data14), .rk_idx_o(rk_idx14), .rk_i(rk14), .out_valid_o(out_valid14),
        .out_ready_i(out_ready14), .out_data_o(out_data14), .busy_o(busy14)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] tb_xtime(input logic [7:0] a);
        return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    endfunction

    // Reference S-box from log/antilog tables over generator 3.
    function automatic logic [7:0] tb_sbox(input logic [7:0] x);
        logic [7:0] inv, s, c;
        c   = 8'h63;
        inv = (x == 8'h00) ? 8'h00 : gexp[(255 - glog[x]) % 255];
        for (int i = 0; i < 8; i++)
            s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
        return s;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] x);
        return {tb_sbox(x[31:24]), tb_sbox(x[23:16]), tb_sbox(x[15:8]), tb_sbox(x[7:0])};
    endfunction

    function automatic state_t to_state(input logic [127:0] b);
        state_t s;
        for (int k = 0; k < 16; k++) s[k % 4][k / 4] = b[127 - 8 * k -: 8];
        return s;
    endfunction

    task automatic expand_key(input logic [255:0] key, input int nk);
        int nr;
        logic [31:0] t;
        logic [7:0] rc;
        nr = nk + 6;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = tb_xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i - nk] ^ t;
        end
    endtask

    task automatic load_rk10();
        for (int r = 0; r <= 10; r++)
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    rk10_tab[r][row][c] = w[4 * r + c][31 - 8 * row -: 8];
    endtask

    task automatic load_rk14();
        for (int r = 0; r <= 14; r++)
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    rk14_tab[r][row][c] = w[4 * r + c][31 - 8 * row -: 8];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] g;
        g = 8'h01;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = g;
            glog[g] = i;
            g = g ^ tb_xtime(g);
        end
        gexp[255] = 8'h01;
        glog[0]   = 0;

        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        in_valid14 = 1'b0; out_ready14 = 1'b0; in_data14 = '0;
        expand_key({KEY_B, 128'h0}, 4);
        load_rk10();
        expand_key(KEY_C3, 8);
        load_rk14();
        step();
        step();

        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_rk_idx", rk_idx, 0);
        chk("rst14_in_ready", in_ready14, 1);
        rst_n = 1'b1;
        step();

        // App.B block; in_valid kept high with junk data throughout RUN.
        in_data  = to_state(PT_B);
        in_valid = 1'b1;
        chk("idle_in_ready", in_ready, 1);
        chk("idle_rk_idx", rk_idx, 0);
        step();
        in_data = '1;
        for (int i = 1; i <= 10; i++) begin
            chk("run_in_ready", in_ready, 0);
            chk("run_rk_idx", rk_idx, i);
            chk("run_out_valid", out_valid, 0);
            chk("run_busy", busy, 1);
            step();
        end
        chk("b_out_valid_cycle11", out_valid, 1);
        chk("b_out_data", out_data, to_state(CT_B));
        chk("done_rk_idx", rk_idx, 0);
        chk("done_in_ready_bp", in_ready, 0);
        in_valid = 1'b0;
        held = out_data;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_out_data", out_data, held);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_busy", busy, 1);
        end
        out_ready = 1'b1;
        #1;
        chk("done_in_ready_follow", in_ready, 1);
        step();
        chk("post_out_valid", out_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_in_ready", in_ready, 1);

        // Back-to-back: the second accept shares the edge of the first output handshake.
        in_data  = to_state(PT_B);
        in_valid = 1'b1;
        step();
        n = 0;
        while (!out_valid && n < 30) begin
            step();
            n++;
        end
        chk("b2b_latency1", n, 10);
        chk("b2b_data1", out_data, to_state(CT_B));
        chk("b2b_in_ready", in_ready, 1);
        step();
        chk("b2b_reaccept_valid", out_valid, 0);
        chk("b2b_reaccept_busy", busy, 1);
        chk("b2b_reaccept_rk_idx", rk_idx, 1);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 30) begin
            step();
            n++;
        end
        chk("b2b_period", n + 1, 11);
        chk("b2b_data2", out_data, to_state(CT_B));
        step();
        chk("b2b_idle", busy, 0);

        // Reset while round_ctr == 4, then a clean block under a new key.
        expand_key({KEY_C1, 128'h0}, 4);
        load_rk10();
        in_data  = to_state(PT_C);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (rk_idx != 4 && n < 20) begin
            step();
            n++;
        end
        chk("abort_reach_ctr4", rk_idx, 4);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_data", out_data, 0);
        chk("abort_busy", busy, 0);
        step();
        rst_n = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 30) begin
            step();
            n++;
        end
        chk("c1_latency", n, 10);
        chk("c1_out_data", out_data, to_state(CT_C1));
        step();
        chk("c1_idle", busy, 0);

        // NR=14 build with the AES-256 vector.
        in_data14  = to_state(PT_C);
        in_valid14 = 1'b1;
        chk("n14_rk_idx0", rk_idx14, 0);
        step();
        in_valid14 = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            chk("n14_rk_idx", rk_idx14, i);
            chk("n14_out_valid", out_valid14, 0);
            step();
        end
        chk("n14_out_valid_cycle15", out_valid14, 1);
        chk("n14_out_data", out_data14, to_state(CT_C3));
        out_ready14 = 1'b1;
        step();
        chk("n14_idle", busy14, 0);
        chk("n14_out_valid_drop", out_valid14, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
